// File: rtl/bash_squeeze_if.sv
// Bus bundle for the bash-f squeeze block: command, state input, permutation
// hand-back and 64-bit output stream.
interface bash_squeeze_if;
    logic           start_i;
    logic [15:0]    len_i;
    logic           state_valid_i;
    logic           state_ready_o;
    logic [1535:0]  state_i;
    logic           perm_req_o;
    logic [1535:0]  perm_state_o;
    logic           perm_ack_i;
    logic [63:0]    dout_o;
    logic           dout_valid_o;
    logic           dout_ready_i;
    logic           dout_last_o;
    logic           busy_o;

    // Seen from the squeeze block.
    modport slave (
        input  start_i, len_i, state_valid_i, state_i, perm_ack_i, dout_ready_i,
        output state_ready_o, perm_req_o, perm_state_o, dout_o, dout_valid_o,
        output dout_last_o, busy_o
    );

    // Seen from the surrounding core / output bus.
    modport master (
        output start_i, len_i, state_valid_i, state_i, perm_ack_i, dout_ready_i,
        input  state_ready_o, perm_req_o, perm_state_o, dout_o, dout_valid_o,
        input  dout_last_o, busy_o
    );
endinterface

// File: rtl/bash_squeeze.sv
// Squeeze side of bash-f: streams the rate part of a 1536-bit state as 64-bit
// words and hands the state back for another permutation when more is needed.
module bash_squeeze #(
    parameter int L         = 256,
    parameter bit BYTE_SWAP = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    bash_squeeze_if.slave bus
);

    localparam int          RATE_WORDS  = (1536 - 4 * L) / 64;
    localparam logic [15:0] DEFAULT_LEN = 16'(2 * L / 64);
    localparam logic [3:0]  LAST_IDX    = 4'(RATE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_ST = 2'd1,
        EMIT    = 2'd2,
        REQ     = 2'd3
    } fsm_e;

    fsm_e           fsm_q, fsm_d;
    logic [1535:0]  held_q, held_d;
    logic [15:0]    rem_q, rem_d;
    logic [3:0]     idx_q, idx_d;
    logic [63:0]    dout_q, dout_d;
    logic           valid_q, valid_d;
    logic           last_q, last_d;

    logic           xfer;

    // Word k sits at the top of the vector for k=0; the bus is big-endian.
    function automatic logic [63:0] pick_word(input logic [1535:0] st,
                                              input logic [3:0]    k);
        logic [63:0] w;
        logic [63:0] s;
        w = st[1535 - 64 * int'(k) -: 64];
        s = w;
        if (BYTE_SWAP) begin
            for (int b = 0; b < 8; b++) begin
                s[8 * b +: 8] = w[56 - 8 * b +: 8];
            end
        end
        return s;
    endfunction

    assign xfer = valid_q && bus.dout_ready_i;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first, so no
        // path through the case below can infer a latch.
        fsm_d   = fsm_q;
        held_d  = held_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        last_d  = last_q;

        unique case (fsm_q)
            IDLE: begin
                if (bus.start_i) begin
                    rem_d = (bus.len_i == 16'd0) ? DEFAULT_LEN : bus.len_i;
                    fsm_d = WAIT_ST;
                end
            end

            WAIT_ST: begin
                // Word 0 is loaded on the accept edge to meet the 1-cycle latency.
                if (bus.state_valid_i) begin
                    held_d  = bus.state_i;
                    idx_d   = 4'd0;
                    dout_d  = pick_word(bus.state_i, 4'd0);
                    valid_d = 1'b1;
                    last_d  = (rem_q == 16'd1);
                    fsm_d   = EMIT;
                end
            end

            EMIT: begin
                if (xfer) begin
                    if (rem_q != 16'd0) begin
                        rem_d = rem_q - 16'd1;
                    end
                    idx_d = idx_q + 4'd1;
                    if (rem_q == 16'd1) begin
                        dout_d  = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        fsm_d   = IDLE;
                    end else if (idx_q == LAST_IDX) begin
                        dout_d  = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        fsm_d   = REQ;
                    end else begin
                        dout_d = pick_word(held_q, idx_q + 4'd1);
                        last_d = (rem_q == 16'd2);
                    end
                end
            end

            REQ: begin
                if (bus.perm_ack_i) begin
                    fsm_d = WAIT_ST;
                end
            end

            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // NOTE: the held state is a plain register (not a memory), so it is reset
    // along with everything else and perm_state_o reads 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            held_q  <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together.
            fsm_q   <= fsm_d;
            held_q  <= held_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign bus.state_ready_o = (fsm_q == WAIT_ST);
    assign bus.perm_req_o    = (fsm_q == REQ);
    assign bus.perm_state_o  = held_q;
    assign bus.dout_o        = dout_q;
    assign bus.dout_valid_o  = valid_q;
    assign bus.dout_last_o   = last_q;
    assign bus.busy_o        = (fsm_q != IDLE);

endmodule

// File: tb/tb_bash_squeeze.sv
// Directed bench for bash_squeeze: L=256 byte-swapped instance for most cases,
// plus an L=128 pass-through instance.
module tb_bash_squeeze;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    bash_squeeze_if bus_a ();
    bash_squeeze_if bus_b ();

    bash_squeeze #(.L(256), .BYTE_SWAP(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    bash_squeeze #(.L(128), .BYTE_SWAP(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input logic [1535:0] st, input int k);
        return st[1535 - 64 * k -: 64];
    endfunction

    function automatic logic [63:0] bswap(input logic [63:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24], w[39:32], w[47:40], w[55:48], w[63:56]};
    endfunction

    // Word k = {hi, k}.
    function automatic logic [1535:0] mk_state(input logic [47:0] hi);
        logic [1535:0] st;
        for (int k = 0; k < 24; k++) st[1535 - 64 * k -: 64] = {hi, 16'(k)};
        return st;
    endfunction

    task automatic start_a(input logic [15:0] len);
        bus_a.start_i = 1'b1;
        bus_a.len_i   = len;
        @(negedge clk);
        bus_a.start_i = 1'b0;
        check("wait_st_ready", 64'(bus_a.state_ready_o), 64'd1);
    endtask

    task automatic supply_a(input logic [1535:0] st);
        int cyc;
        cyc = 0;
        while (!bus_a.state_ready_o && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("state_ready_wait", 64'(bus_a.state_ready_o), 64'd1);
        bus_a.state_valid_i = 1'b1;
        bus_a.state_i       = st;
        @(negedge clk);
        bus_a.state_valid_i = 1'b0;
        check("first_valid_lat", 64'(bus_a.dout_valid_o), 64'd1);
    endtask

    // Collects n words starting at index first; returns at the negedge after
    // the last transfer.
    task automatic expect_words(input logic [1535:0] st, input int first, input int n,
                                input bit last_at_end, input bit toggle);
        int          got;
        int          cyc;
        bit          stalled;
        logic [63:0] held;
        got = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (got < n && cyc < 200) begin
            bus_a.dout_ready_i = toggle ? (((cyc / 2) % 2) == 1) : 1'b1;
            if (stalled) begin
                check("stall_valid", 64'(bus_a.dout_valid_o), 64'd1);
                check("stall_data", bus_a.dout_o, held);
            end
            if (bus_a.dout_valid_o) begin
                if (bus_a.dout_ready_i) begin
                    check("word", bus_a.dout_o, bswap(word_of(st, first + got)));
                    check("last", 64'(bus_a.dout_last_o),
                          64'(last_at_end && (got == n - 1)));
                    got++;
                    stalled = 1'b0;
                end else begin
                    held    = bus_a.dout_o;
                    stalled = 1'b1;
                end
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check("word_count", 64'(got), 64'(n));
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_valid"}, 64'(bus_a.dout_valid_o), 64'd0);
        check({tag, "_busy"}, 64'(bus_a.busy_o), 64'd0);
        check({tag, "_perm_req"}, 64'(bus_a.perm_req_o), 64'd0);
    endtask

    logic [1535:0] st_a, st_b, st_c, st_d, st_e;

    initial begin
        checks = 0; failures = 0;
        st_a = mk_state(48'h0);
        st_b = mk_state(48'hb0b0_0000_0000);
        st_c = mk_state(48'hc0c0_0000_0000);
        st_d = mk_state(48'hd0d0_1234_0000);
        st_e = mk_state(48'h0);
        st_e[1535 -: 64] = 64'h0123_4567_89ab_cdef;

        bus_a.start_i = 0; bus_a.len_i = 0; bus_a.state_valid_i = 0; bus_a.state_i = '0;
        bus_a.perm_ack_i = 0; bus_a.dout_ready_i = 1;
        bus_b.start_i = 0; bus_b.len_i = 0; bus_b.state_valid_i = 0; bus_b.state_i = '0;
        bus_b.perm_ack_i = 0; bus_b.dout_ready_i = 1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(bus_a.dout_valid_o), 64'd0);
        check("rst_dout", bus_a.dout_o, 64'd0);
        check("rst_ready", 64'(bus_a.state_ready_o), 64'd0);
        check("rst_busy", 64'(bus_a.busy_o), 64'd0);
        check("rst_perm_req", 64'(bus_a.perm_req_o), 64'd0);
        check("rst_perm_state", 64'(bus_a.perm_state_o == '0), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // L=256, len 0 -> 8 words; hand-computed first two swapped words.
        start_a(16'd0);
        check("busy_wait_st", 64'(bus_a.busy_o), 64'd1);
        supply_a(st_a);
        check("hash_w0_const", bus_a.dout_o, 64'h0000_0000_0000_0000);
        bus_a.dout_ready_i = 1'b1;
        @(negedge clk);
        check("hash_w1_const", bus_a.dout_o, 64'h0100_0000_0000_0000);
        expect_words(st_a, 1, 7, 1'b1, 1'b0);
        check_idle_a("hash_end");
        repeat (2) @(negedge clk);
        check_idle_a("hash_quiet");

        // Same run under toggling backpressure.
        start_a(16'd0);
        supply_a(st_a);
        expect_words(st_a, 0, 8, 1'b1, 1'b1);
        check_idle_a("bp_end");
        bus_a.dout_ready_i = 1'b1;
        @(negedge clk);

        // Multi-block: 8 from A, 8 from B, 4 from C.
        start_a(16'd20);
        supply_a(st_a);
        expect_words(st_a, 0, 8, 1'b0, 1'b0);
        check("req_a", 64'(bus_a.perm_req_o), 64'd1);
        check("req_a_state", 64'(bus_a.perm_state_o == st_a), 64'd1);
        check("req_a_valid", 64'(bus_a.dout_valid_o), 64'd0);
        check("req_a_ready", 64'(bus_a.state_ready_o), 64'd0);
        @(negedge clk);
        check("req_a_hold", 64'(bus_a.perm_req_o), 64'd1);
        bus_a.perm_ack_i = 1'b1;
        @(negedge clk);
        bus_a.perm_ack_i = 1'b0;
        check("ack_a_wait", 64'(bus_a.state_ready_o), 64'd1);
        check("ack_a_req", 64'(bus_a.perm_req_o), 64'd0);
        supply_a(st_b);
        expect_words(st_b, 0, 8, 1'b0, 1'b0);
        check("req_b", 64'(bus_a.perm_req_o), 64'd1);
        check("req_b_state", 64'(bus_a.perm_state_o == st_b), 64'd1);
        bus_a.perm_ack_i = 1'b1;
        @(negedge clk);
        bus_a.perm_ack_i = 1'b0;
        supply_a(st_c);
        expect_words(st_c, 0, 4, 1'b1, 1'b0);
        check_idle_a("multi_end");
        @(negedge clk);

        // Reset during EMIT after 3 transfers, then a fresh len=2 squeeze.
        start_a(16'd0);
        supply_a(st_a);
        expect_words(st_a, 0, 3, 1'b0, 1'b0);
        bus_a.dout_ready_i = 1'b0;
        check("pre_rst_valid", 64'(bus_a.dout_valid_o), 64'd1);
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(bus_a.dout_valid_o), 64'd0);
        check("arst_dout", bus_a.dout_o, 64'd0);
        check("arst_last", 64'(bus_a.dout_last_o), 64'd0);
        check("arst_busy", 64'(bus_a.busy_o), 64'd0);
        check("arst_perm_state", 64'(bus_a.perm_state_o == '0), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        bus_a.dout_ready_i = 1'b1;
        @(negedge clk);
        check_idle_a("post_rst");
        start_a(16'd2);
        supply_a(st_d);
        expect_words(st_d, 0, 2, 1'b1, 1'b0);
        check_idle_a("post_rst_end");
        @(negedge clk);

        // Ignored events in EMIT, then perm_ack_i in IDLE.
        start_a(16'd0);
        supply_a(st_a);
        expect_words(st_a, 0, 2, 1'b0, 1'b0);
        bus_a.dout_ready_i  = 1'b0;
        bus_a.start_i       = 1'b1;
        bus_a.len_i         = 16'd5;
        bus_a.state_valid_i = 1'b1;
        bus_a.state_i       = st_d;
        @(negedge clk);
        bus_a.start_i = 1'b0;
        bus_a.state_valid_i = 1'b0;
        check("ign_dout", bus_a.dout_o, bswap(word_of(st_a, 2)));
        check("ign_valid", 64'(bus_a.dout_valid_o), 64'd1);
        check("ign_ready", 64'(bus_a.state_ready_o), 64'd0);
        expect_words(st_a, 2, 6, 1'b1, 1'b0);
        check_idle_a("ign_end");
        bus_a.perm_ack_i = 1'b1;
        @(negedge clk);
        bus_a.perm_ack_i = 1'b0;
        check_idle_a("ack_idle");
        check("ack_idle_ready", 64'(bus_a.state_ready_o), 64'd0);

        // L=128 pass-through, len 4.
        bus_b.start_i = 1'b1;
        bus_b.len_i   = 16'd4;
        @(negedge clk);
        bus_b.start_i = 1'b0;
        check("b_ready", 64'(bus_b.state_ready_o), 64'd1);
        bus_b.state_valid_i = 1'b1;
        bus_b.state_i       = st_e;
        @(negedge clk);
        bus_b.state_valid_i = 1'b0;
        check("b_w0_const", bus_b.dout_o, 64'h0123_4567_89ab_cdef);
        for (int i = 0; i < 4; i++) begin
            check("b_valid", 64'(bus_b.dout_valid_o), 64'd1);
            check("b_word", bus_b.dout_o, word_of(st_e, i));
            check("b_last", 64'(bus_b.dout_last_o), 64'(i == 3));
            @(negedge clk);
        end
        check("b_end_valid", 64'(bus_b.dout_valid_o), 64'd0);
        check("b_end_busy", 64'(bus_b.busy_o), 64'd0);
        check("b_end_req", 64'(bus_b.perm_req_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bash_squeeze.md
Name: bash_squeeze

Overview:
- Output (reader) side of the bash-f datapath.
- Takes the 1536-bit state produced by the bash-f round pipeline and streams the digest / squeeze output as 64-bit words over a valid/ready interface.
- When more output is requested than one rate block holds, it hands the held state back to the permutation and waits for the permuted state before continuing.
- Sits between the bash-f core and the hash output bus.

Parameters:
- L, 256, security level in bits. Legal values: 128, 192, 256.
- BYTE_SWAP, 1, 1 = each output word is byte-reversed (state words are little-endian, the bus is big-endian); 0 = pass-through.
- Derived localparam RATE_WORDS = (1536 - 4*L)/64. Values: 16 / 12 / 8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-high.
- start_i  in  1  begin a squeeze. Accepted only in IDLE.
- len_i  in  16  number of 64-bit words to emit. Sampled on start. 0 is treated as 2*L/64.
- state_valid_i  in  1  state_i holds a valid state.
- state_ready_o  out  1  block accepts state_i.
- state_i  in  1536  state. Word k = state_i[1535-64k -: 64].
- perm_req_o  out  1  request a bash-f pass on perm_state_o.
- perm_state_o  out  1536  held state, presented with perm_req_o.
- perm_ack_i  in  1  upstream has taken perm_state_o.
- dout_o  out  64  output word.
- dout_valid_o  out  1  dout_o valid.
- dout_ready_i  in  1  sink accepts dout_o.
- dout_last_o  out  1  marks the final word of the squeeze.
- busy_o  out  1  block is not in IDLE.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, word counters 0, state register 0.
- FSM states: IDLE, WAIT_ST, EMIT, REQ.
  - IDLE: on start_i, latch remaining = (len_i==0 ? 2L/64 : len_i) and go to WAIT_ST.
  - WAIT_ST: state_ready_o=1. On state_valid_i, register state_i, set idx=0, go to EMIT.
  - EMIT: dout_o = word idx of the held state, byte-swapped if BYTE_SWAP. dout_valid_o=1. dout_o, dout_valid_o and dout_last_o are registered outputs.
  - Handshake in EMIT: a transfer occurs when dout_valid_o && dout_ready_i. On transfer, remaining--, idx++.
    - If remaining was 1: go to IDLE. dout_last_o was 1 for that word.
    - Else if idx was RATE_WORDS-1: go to REQ.
    - Else stay in EMIT, and the next word appears on the following cycle.
  - REQ: perm_req_o=1 and perm_state_o=held state. On perm_ack_i, go to WAIT_ST.
- dout_valid_o must not drop, and dout_o/dout_last_o must not change, while dout_valid_o=1 and dout_ready_i=0.
- Throughput: one word per cycle with continuous ready.
- Latency:
  - start to WAIT_ST: 1 cycle.
  - state accept to first dout_valid_o: 1 cycle.
  - last transfer to IDLE: same edge. The next start is accepted the cycle after.
- Rate block boundary:
  - When remaining > RATE_WORDS, only words 0..RATE_WORDS-1 of each state are emitted.
  - The upper capacity words are never output.
- start_i outside IDLE is ignored.
- state_valid_i outside WAIT_ST is ignored; state_ready_o=0 there.
- perm_ack_i outside REQ is ignored.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. A partial squeeze is discarded and nothing is resumed.
- busy_o=1 in WAIT_ST, EMIT and REQ.
- Counters: remaining is 16 bits and never wraps, because it is decremented only while nonzero. idx width is ceil(log2(16)) = 4 bits.

Test Plan:
- Hash output, L=256, len_i=0: state word k = {48'h0, 16'hk} → exactly 8 words k=0..7. Byte-swapped, the first word is 64'h0000_0000_0000_0000 and the second is 64'h0100_0000_0000_0000. dout_last_o only on word 7. No perm_req_o.
- Backpressure: same run with dout_ready_i toggling every 2 cycles → dout_o and dout_valid_o stay stable while stalled. The word sequence is unchanged and exactly 8 transfers occur.
- Multi-block, L=256, len_i=20:
  - 8 words from state A, then perm_req_o with perm_state_o=A.
  - Ack, supply state B → 8 words from B, then REQ again.
  - Supply C → 4 words from C, with last on C word 3.
- L=128, BYTE_SWAP=0, len_i=4 with input 64'h0123456789abcdef in word 0 → dout_o = 64'h0123456789abcdef first. 4 words, last on word 3.
- Reset asserted during EMIT after 3 transfers → all outputs 0 asynchronously. A new start/len_i=2 then produces 2 words from freshly supplied state.
- Ignored events: start_i in EMIT, state_valid_i in EMIT, perm_ack_i in IDLE → no change in word count, sequence or FSM state.
